tfaw_act_gate: RTL and testbench
================================

TFAW_ACT_GATE -- requirements
Module: tfaw_act_gate

Interface
REQ-001 SHALL have parameter CMD_TYPE_WIDTH, default 3, width of command-type encoding.
REQ-002 SHALL have parameter ACT_BITS, default 3'b010, ACT command encoding.
REQ-003 SHALL have parameter TIME_CONSTRAINT_WIDTH, default 8, width of all timing counters.
REQ-004 SHALL have parameter tFAW, default 36, four-activate window in cycles, legal range 1..2^TIME_CONSTRAINT_WIDTH-1.
REQ-005 SHALL have parameter tRRD, default 4, minimum ACT-to-ACT spacing in cycles, legal range 1..tFAW.
REQ-006 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-007 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have port act_req_valid  input  1  scheduler requests an ACT to this rank.
REQ-009 SHALL have port act_block  input  1  external hold, e.g. refresh pending; forces act_req_ready low.
REQ-010 SHALL have port act_req_ready  output  1  ACT may issue this cycle; combinational from registered state and act_block only.
REQ-011 SHALL have port act_issue  output  1  registered one-cycle pulse, one cycle after each accepted ACT.
REQ-012 SHALL have port act_cmd  output  CMD_TYPE_WIDTH  ACT_BITS while act_issue=1, else 0.
REQ-013 SHALL have port faw_count  output  3  number of valid window slots, 0..4.
REQ-014 SHALL have port faw_wait  output  TIME_CONSTRAINT_WIDTH  oldest slot counter when faw_count=4, else 0.
REQ-015 SHALL have port gate_state  output  2  FSM state: 0 OPEN, 1 RRD_WAIT, 2 FAW_FULL.

Function
REQ-016 SHALL hold four window slots, each a counter and a valid bit; slot 0 newest, slot 3 oldest.
REQ-017 SHALL accept an ACT (handshake) in any cycle where act_req_valid=1 and act_req_ready=1.
REQ-018 SHALL drive act_req_ready = !act_block && (faw_count<4) && (rrd_cnt==0), evaluated from registered state.
REQ-019 SHALL, on handshake, shift slots 2->3, 1->2, 0->1 and load slot 0 with counter tFAW-1, valid=1.
REQ-020 SHALL, every cycle after any shift/load, decrement each nonzero slot counter by 1, saturating at 0.
REQ-021 SHALL clear a slot's valid bit in the same edge its counter reaches 0; a loaded tFAW-1 of 0 (tFAW=1) leaves the slot invalid.
REQ-022 SHALL, on handshake, load rrd_cnt with tRRD-1; otherwise decrement rrd_cnt saturating at 0.
REQ-023 SHALL guarantee that an ACT accepted in cycle T permits the next ACT no earlier than T+tRRD and the fifth-following ACT no earlier than T+tFAW.
REQ-024 SHALL never discard a valid slot 3; a shift with slot 3 valid is impossible because ready=0 when faw_count=4.
REQ-025 SHALL compute gate_state from post-edge registers: FAW_FULL if faw_count=4, else RRD_WAIT if rrd_cnt!=0, else OPEN; act_block does not affect gate_state.
REQ-026 SHALL update faw_count, faw_wait and gate_state as registered outputs consistent with the slot registers.
REQ-027 SHALL, when a slot expires in the same edge a handshake occurs, apply the shift first, then decrement/expire.
REQ-028 SHALL not register or stall act_req_valid; a request not accepted leaves all state unchanged except countdown.

Reset
REQ-029 SHALL, while rst_n=0, asynchronously clear all slot counters, valid bits and rrd_cnt to 0.
REQ-030 SHALL, during reset, drive act_issue=0, act_cmd=0, faw_count=0, faw_wait=0, gate_state=OPEN.
REQ-031 SHALL, after reset release, drive act_req_ready=!act_block; a reset mid-window discards all window history.

Verification
REQ-032 SHALL cover: defaults, act_req_valid held 1 from cycle 0 after reset -> accepts at cycles 0,4,8,12,36,40,44,48; act_issue pulses at 1,5,9,13,37.
REQ-033 SHALL cover: after 4th ACT at cycle 12 -> faw_count=4, gate_state=FAW_FULL from cycle 13, faw_wait=23 at cycle 13, decrementing to 1 at cycle 35; faw_count=3 at cycle 36.
REQ-034 SHALL cover: single ACT at cycle 0 -> gate_state=RRD_WAIT cycles 1..3, OPEN cycle 4; faw_count=1 cycles 1..35, 0 at cycle 36.
REQ-035 SHALL cover: act_block=1 cycles 0..9 with valid held -> no accept; first accept at cycle 10, gate_state stays OPEN during block.
REQ-036 SHALL cover: rst_n asserted at cycle 20 after four ACTs -> all outputs zero immediately; after release act_req_ready=1 next cycle.
REQ-037 SHALL cover: tFAW=1, tRRD=1, valid held -> accept every cycle, act_issue held 1, faw_count always 0.

Source files
------------

// File: rtl/tfaw_act_gate.sv
// tfaw_act_gate: per-rank ACT admission gate enforcing tRRD spacing and the
// tFAW four-activate rolling window. A four-slot history of recent ACTs ages
// down each cycle; a new ACT is admitted only when fewer than four slots are
// live and the ACT-to-ACT spacing counter has drained.
module tfaw_act_gate #(
  parameter int                        CMD_TYPE_WIDTH        = 3,
  parameter logic [CMD_TYPE_WIDTH-1:0] ACT_BITS              = 3'b010,
  parameter int                        TIME_CONSTRAINT_WIDTH = 8,
  parameter int                        tFAW                  = 36,
  parameter int                        tRRD                  = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             act_req_valid,
  input  logic                             act_block,
  output logic                             act_req_ready,
  output logic                             act_issue,
  output logic [CMD_TYPE_WIDTH-1:0]        act_cmd,
  output logic [2:0]                       faw_count,
  output logic [TIME_CONSTRAINT_WIDTH-1:0] faw_wait,
  output logic [1:0]                       gate_state
);

  localparam int TW = TIME_CONSTRAINT_WIDTH;

  // Values loaded on an accepted ACT; the load itself is not aged that edge.
  localparam logic [TW-1:0] FAW_LOAD = TW'(tFAW - 1);
  localparam logic [TW-1:0] RRD_LOAD = TW'(tRRD - 1);
  localparam logic [TW-1:0] ONE      = TW'(1);

  typedef enum logic [1:0] {
    GATE_OPEN     = 2'd0,
    GATE_RRD_WAIT = 2'd1,
    GATE_FAW_FULL = 2'd2
  } gate_state_e;

  logic [TW-1:0]             slot_cnt_q [4];
  logic [TW-1:0]             slot_cnt_d [4];
  logic [TW-1:0]             shift_cnt  [4];
  logic [3:0]                slot_vld_q, slot_vld_d, shift_vld;
  logic [TW-1:0]             rrd_cnt_q, rrd_cnt_d;
  logic                      act_issue_q, act_issue_d;
  logic [CMD_TYPE_WIDTH-1:0] act_cmd_q, act_cmd_d;
  logic [2:0]                faw_count_q, faw_count_d;
  logic [TW-1:0]             faw_wait_q, faw_wait_d;
  gate_state_e               state_q, state_d;
  logic                      handshake;

  // Admission depends only on registered window state and the external hold;
  // a full window already guarantees slot 3 is never shifted out while live.
  assign act_req_ready = !act_block && (faw_count_q < 3'd4) && (rrd_cnt_q == '0);
  assign handshake     = act_req_valid && act_req_ready;

  // Shift the window on an accepted ACT first, then age and expire every
  // slot except the one just loaded; derived outputs follow the new slots.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      shift_cnt[i] = slot_cnt_q[i];
    end
    shift_vld = slot_vld_q;
    if (handshake) begin
      for (int i = 3; i > 0; i--) begin
        shift_cnt[i] = slot_cnt_q[i-1];
        shift_vld[i] = slot_vld_q[i-1];
      end
      shift_cnt[0] = FAW_LOAD;
      shift_vld[0] = 1'b1;
    end

    for (int i = 0; i < 4; i++) begin
      if (handshake && (i == 0)) begin
        slot_cnt_d[i] = FAW_LOAD;
        slot_vld_d[i] = (FAW_LOAD != '0);
      end else if (shift_cnt[i] != '0) begin
        slot_cnt_d[i] = shift_cnt[i] - ONE;
        slot_vld_d[i] = shift_vld[i] && (shift_cnt[i] != ONE);
      end else begin
        slot_cnt_d[i] = '0;
        slot_vld_d[i] = 1'b0;
      end
    end

    if (handshake) begin
      rrd_cnt_d = RRD_LOAD;
    end else if (rrd_cnt_q != '0) begin
      rrd_cnt_d = rrd_cnt_q - ONE;
    end else begin
      rrd_cnt_d = '0;
    end

    faw_count_d = 3'd0;
    for (int i = 0; i < 4; i++) begin
      faw_count_d = faw_count_d + {2'b00, slot_vld_d[i]};
    end
    faw_wait_d = (faw_count_d == 3'd4) ? slot_cnt_d[3] : '0;

    if (faw_count_d == 3'd4) begin
      state_d = GATE_FAW_FULL;
    end else if (rrd_cnt_d != '0) begin
      state_d = GATE_RRD_WAIT;
    end else begin
      state_d = GATE_OPEN;
    end

    act_issue_d = handshake;
    act_cmd_d   = handshake ? ACT_BITS : '0;
  end

  // All window state and outputs are registered; reset discards all history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        slot_cnt_q[i] <= '0;
      end
      slot_vld_q  <= '0;
      rrd_cnt_q   <= '0;
      act_issue_q <= 1'b0;
      act_cmd_q   <= '0;
      faw_count_q <= 3'd0;
      faw_wait_q  <= '0;
      state_q     <= GATE_OPEN;
    end else begin
      for (int i = 0; i < 4; i++) begin
        slot_cnt_q[i] <= slot_cnt_d[i];
      end
      slot_vld_q  <= slot_vld_d;
      rrd_cnt_q   <= rrd_cnt_d;
      act_issue_q <= act_issue_d;
      act_cmd_q   <= act_cmd_d;
      faw_count_q <= faw_count_d;
      faw_wait_q  <= faw_wait_d;
      state_q     <= state_d;
    end
  end

  assign act_issue  = act_issue_q;
  assign act_cmd    = act_cmd_q;
  assign faw_count  = faw_count_q;
  assign faw_wait   = faw_wait_q;
  assign gate_state = state_q;

endmodule

// File: tb/tb_tfaw_act_gate.sv
// tb_tfaw_act_gate: directed and randomized checks of the ACT gate against a
// reference model built from the ACT history (a list of accept cycles).
module tb_tfaw_act_gate;

  localparam int FAW      = 36;
  localparam int RRD      = 4;
  localparam int ACT_CODE = 2;

  logic       clk;
  logic       rst_n;
  logic       act_req_valid, act_block, act_req_ready, act_issue;
  logic [2:0] act_cmd;
  logic [2:0] faw_count;
  logic [7:0] faw_wait;
  logic [1:0] gate_state;

  logic       f_valid, f_block, f_ready, f_issue;
  logic [2:0] f_cmd;
  logic [2:0] f_count;
  logic [7:0] f_wait;
  logic [1:0] f_state;

  int checks = 0;
  int errors = 0;

  int accQ[$];
  int dutAcc[$];
  int lastAcc;
  bit hasLast;
  bit prevAcc;
  bit fPrev;
  int cyc;
  int obsIssue[64];
  int obsCount[64];
  int obsWait[64];
  int obsState[64];

  tfaw_act_gate dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .act_req_valid (act_req_valid),
    .act_block     (act_block),
    .act_req_ready (act_req_ready),
    .act_issue     (act_issue),
    .act_cmd       (act_cmd),
    .faw_count     (faw_count),
    .faw_wait      (faw_wait),
    .gate_state    (gate_state)
  );

  tfaw_act_gate #(.tFAW(1), .tRRD(1)) dutFast (
    .clk           (clk),
    .rst_n         (rst_n),
    .act_req_valid (f_valid),
    .act_block     (f_block),
    .act_req_ready (f_ready),
    .act_issue     (f_issue),
    .act_cmd       (f_cmd),
    .faw_count     (f_count),
    .faw_wait      (f_wait),
    .gate_state    (f_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", tag, cyc, observed, expected);
    end
  endtask

  // ACTs still occupying the window at cycle cyc were accepted 1..FAW-1 cycles ago.
  function automatic int modelCount();
    int n = 0;
    foreach (accQ[i]) if ((cyc - accQ[i] >= 1) && (cyc - accQ[i] <= FAW - 1)) n++;
    return n;
  endfunction

  function automatic int modelWait();
    int oldest = cyc;
    if (modelCount() != 4) return 0;
    foreach (accQ[i])
      if ((cyc - accQ[i] >= 1) && (cyc - accQ[i] <= FAW - 1) && (accQ[i] < oldest)) oldest = accQ[i];
    return FAW - (cyc - oldest);
  endfunction

  function automatic int modelRrd();
    if (!hasLast) return 0;
    if (cyc - lastAcc >= RRD) return 0;
    return RRD - (cyc - lastAcc);
  endfunction

  function automatic bit modelReady(input bit blk);
    return !blk && (modelCount() < 4) && (modelRrd() == 0);
  endfunction

  function automatic int modelState();
    if (modelCount() == 4) return 2;
    if (modelRrd() != 0) return 1;
    return 0;
  endfunction

  task automatic applyStimulus(input bit v, input bit b, input bit fb);
    bit expReady;
    act_req_valid = v;
    act_block     = b;
    f_valid       = 1'b1;
    f_block       = fb;
    @(negedge clk);
    expReady = modelReady(b);
    checkOutput("ready", act_req_ready, expReady);
    checkOutput("issue", act_issue, prevAcc);
    checkOutput("cmd", act_cmd, prevAcc ? ACT_CODE : 0);
    checkOutput("faw_count", faw_count, modelCount());
    checkOutput("faw_wait", faw_wait, modelWait());
    checkOutput("gate_state", gate_state, modelState());
    checkOutput("fast_ready", f_ready, !fb);
    checkOutput("fast_issue", f_issue, fPrev);
    checkOutput("fast_cmd", f_cmd, fPrev ? ACT_CODE : 0);
    checkOutput("fast_count", f_count, 0);
    checkOutput("fast_wait", f_wait, 0);
    checkOutput("fast_state", f_state, 0);
    if (cyc < 64) begin
      obsIssue[cyc] = int'(act_issue);
      obsCount[cyc] = int'(faw_count);
      obsWait[cyc]  = int'(faw_wait);
      obsState[cyc] = int'(gate_state);
    end
    if (v && act_req_ready) dutAcc.push_back(cyc);
    if (v && expReady) begin
      accQ.push_back(cyc);
      lastAcc = cyc;
      hasLast = 1'b1;
    end
    prevAcc = v && expReady;
    fPrev   = !fb;
    while ((accQ.size() > 0) && (cyc - accQ[0] >= FAW)) void'(accQ.pop_front());
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    #2;
    checkOutput("rst_issue", act_issue, 0);
    checkOutput("rst_cmd", act_cmd, 0);
    checkOutput("rst_count", faw_count, 0);
    checkOutput("rst_wait", faw_wait, 0);
    checkOutput("rst_state", gate_state, 0);
    checkOutput("rst_fast_issue", f_issue, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    accQ.delete();
    dutAcc.delete();
    hasLast = 1'b0;
    prevAcc = 1'b0;
    fPrev   = 1'b0;
    cyc     = 0;
  endtask

  initial begin
    int expAcc[8];
    expAcc = '{0, 4, 8, 12, 36, 40, 44, 48};
    act_req_valid = 1'b0;
    act_block     = 1'b0;
    f_valid       = 1'b1;
    f_block       = 1'b0;
    cyc           = 0;

    // Request held from cycle 0: tRRD spacing then tFAW window stall.
    doReset();
    for (int i = 0; i < 50; i++) applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("acc_total", dutAcc.size(), 8);
    for (int k = 0; k < 8; k++)
      checkOutput("acc_cycle", (k < dutAcc.size()) ? dutAcc[k] : -1, expAcc[k]);
    checkOutput("issue_c1", obsIssue[1], 1);
    checkOutput("issue_c2", obsIssue[2], 0);
    checkOutput("issue_c13", obsIssue[13], 1);
    checkOutput("issue_c37", obsIssue[37], 1);
    checkOutput("count_c13", obsCount[13], 4);
    checkOutput("state_c13", obsState[13], 2);
    checkOutput("wait_c13", obsWait[13], 23);
    checkOutput("wait_c35", obsWait[35], 1);
    checkOutput("count_c36", obsCount[36], 3);

    // Single ACT: RRD_WAIT for three cycles, window slot ages out at 36.
    doReset();
    applyStimulus(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) applyStimulus(1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 3; k++) checkOutput("single_state_rrd", obsState[k], 1);
    checkOutput("single_state_c4", obsState[4], 0);
    checkOutput("single_count_c1", obsCount[1], 1);
    checkOutput("single_count_c35", obsCount[35], 1);
    checkOutput("single_count_c36", obsCount[36], 0);

    // External hold for ten cycles with request pending.
    doReset();
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("block_first_acc", (dutAcc.size() > 0) ? dutAcc[0] : -1, 10);
    for (int k = 0; k < 10; k++) checkOutput("block_state", obsState[k], 0);

    // Reset mid-window after four ACTs.
    doReset();
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'b0, 1'b0);
    doReset();
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("post_rst_acc", (dutAcc.size() > 0) ? dutAcc[0] : -1, 0);

    // Randomized traffic with occasional holds and resets.
    doReset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) doReset();
      applyStimulus($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 15);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
